// File: rtl/conv3x3_mac.sv
// conv3x3_mac: four-stage pipelined 3x3 signed fixed-point convolution MAC.
// Stage 1 captures the nine products and the bias, stage 2 forms the row sums,
// stage 3 adds the aligned bias, and stage 4 rounds, saturates and optionally
// applies ReLU before presenting the result with a one-cycle out_valid strobe.
// The accepting edge is the first of four edges, so a window presented in one
// cycle yields out_valid four cycles later, and the pipeline sustains one
// window per clock.
module conv3x3_mac #(
    parameter int FRAC_BITS = 8,
    parameter bit RELU_EN   = 1'b0
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [15:0] weights_1_1,
    input  logic [15:0] weights_1_2,
    input  logic [15:0] weights_1_3,
    input  logic [15:0] weights_2_1,
    input  logic [15:0] weights_2_2,
    input  logic [15:0] weights_2_3,
    input  logic [15:0] weights_3_1,
    input  logic [15:0] weights_3_2,
    input  logic [15:0] weights_3_3,
    input  logic [15:0] bias,
    input  logic        weights_ready,
    input  logic [15:0] pix_1_1,
    input  logic [15:0] pix_1_2,
    input  logic [15:0] pix_1_3,
    input  logic [15:0] pix_2_1,
    input  logic [15:0] pix_2_2,
    input  logic [15:0] pix_2_3,
    input  logic [15:0] pix_3_1,
    input  logic [15:0] pix_3_2,
    input  logic [15:0] pix_3_3,
    input  logic        in_valid,
    output logic [15:0] conv_out,
    output logic        out_valid,
    output logic        busy,
    output logic        drop_err
);

    localparam logic signed [35:0] ROUND_C = (FRAC_BITS == 0) ? 36'sd0 : (36'sd1 <<< (FRAC_BITS - 1));
    localparam logic signed [35:0] SAT_MAX = 36'sd32767;
    localparam logic signed [35:0] SAT_MIN = -36'sd32768;

    logic signed [15:0] wArr [9];
    logic signed [15:0] pArr [9];

    logic               accept;
    logic               drop;

    logic signed [31:0] prod_d [9];
    logic signed [31:0] prod_q [9];
    logic signed [15:0] bias1_q;
    logic               v1_q;

    logic signed [33:0] rowSum_d [3];
    logic signed [33:0] rowSum_q [3];
    logic signed [15:0] bias2_q;
    logic               v2_q;

    logic signed [35:0] total_d;
    logic signed [35:0] total_q;
    logic               v3_q;

    logic signed [35:0] rounded;
    logic signed [35:0] shifted;
    logic        [15:0] result_d;
    logic        [15:0] conv_out_q;
    logic               out_valid_q;
    logic               drop_err_d;
    logic               drop_err_q;

    assign wArr[0] = weights_1_1;
    assign wArr[1] = weights_1_2;
    assign wArr[2] = weights_1_3;
    assign wArr[3] = weights_2_1;
    assign wArr[4] = weights_2_2;
    assign wArr[5] = weights_2_3;
    assign wArr[6] = weights_3_1;
    assign wArr[7] = weights_3_2;
    assign wArr[8] = weights_3_3;

    assign pArr[0] = pix_1_1;
    assign pArr[1] = pix_1_2;
    assign pArr[2] = pix_1_3;
    assign pArr[3] = pix_2_1;
    assign pArr[4] = pix_2_2;
    assign pArr[5] = pix_2_3;
    assign pArr[6] = pix_3_1;
    assign pArr[7] = pix_3_2;
    assign pArr[8] = pix_3_3;

    assign accept = in_valid & weights_ready;
    assign drop   = in_valid & ~weights_ready;

    // Full-precision signed products of each weight/pixel pair; cannot overflow 32 bits.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod_d[i] = 32'(wArr[i]) * 32'(pArr[i]);
        end
    end

    // Stage 1: freeze products and bias at the accepting edge so later weight changes cannot leak in.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
            bias1_q <= '0;
            v1_q    <= 1'b0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
                bias1_q <= bias;
            end
        end
    end

    // Row sums with two guard bits so three products never wrap.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            rowSum_d[r] = 34'(prod_q[3*r]) + 34'(prod_q[3*r+1]) + 34'(prod_q[3*r+2]);
        end
    end

    // Stage 2: register row sums and carry the bias along with its sample.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) rowSum_q[r] <= '0;
            bias2_q <= '0;
            v2_q    <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                for (int r = 0; r < 3; r++) rowSum_q[r] <= rowSum_d[r];
                bias2_q <= bias1_q;
            end
        end
    end

    // Grand total with the bias aligned to the product's doubled fractional point.
    always_comb begin
        total_d = 36'(rowSum_q[0]) + 36'(rowSum_q[1]) + 36'(rowSum_q[2])
                + (36'(bias2_q) <<< FRAC_BITS);
    end

    // Stage 3: register the 36-bit total.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
            v3_q    <= 1'b0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) total_q <= total_d;
        end
    end

    // Round half-up, rescale, saturate to 16 bits, then optionally clamp negatives.
    always_comb begin
        rounded = total_q + ROUND_C;
        shifted = rounded >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            result_d = 16'h7FFF;
        end else if (shifted < SAT_MIN) begin
            result_d = 16'h8000;
        end else begin
            result_d = shifted[15:0];
        end
        if (RELU_EN && result_d[15]) begin
            result_d = 16'h0000;
        end
    end

    // Stage 4: present the result; conv_out holds between strobes.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            conv_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v3_q;
            if (v3_q) conv_out_q <= result_d;
        end
    end

    // Sticky flag for any window offered while the weight set was not ready.
    always_comb begin
        drop_err_d = drop_err_q | drop;
    end

    // Hold the drop flag until reset.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err_q <= 1'b0;
        end else begin
            drop_err_q <= drop_err_d;
        end
    end

    assign conv_out  = conv_out_q;
    assign out_valid = out_valid_q;
    assign busy      = v1_q | v2_q | v3_q | out_valid_q;
    assign drop_err  = drop_err_q;

endmodule
